booth_precompute_unit: RTL

BOOTH_PRECOMPUTE_UNIT -- requirements
Module: booth_precompute_unit

---
 rtl/booth_precompute_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/booth_precompute_unit.sv
// Booth multiplier front end. It registers the multiplicand multiples (1x, 2x, 3x, 4x) and
// the eight radix-8 booth codes of the multiplier in a two-stage valid/ready pipeline.
module booth_precompute_unit #(
  parameter int LOW_W = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [23:0]     a,
  input  logic [23:0]     b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [23:0]     x,
  output logic [24:0]     x_2,
  output logic [25:0]     x_3,
  output logic [25:0]     x_4,
  output logic [7:0][4:0] BEU_out
);

  localparam int HI_W = 26 - LOW_W;

  logic            s1_valid;
  logic            s2_valid;
  logic [23:0]     s1_a;
  logic [7:0][4:0] s1_code;
  logic [24:0]     s1_x2;
  logic [25:0]     s1_x4;
  logic [LOW_W-1:0] s1_lo;
  logic            s1_cy;

  logic            s2_load;
  logic            in_xfer;
  logic [LOW_W:0]  lo_sum;
  logic [HI_W-1:0] hi_sum;
  logic [24:0]     b_ext;
  logic [7:0][4:0] code_nxt;

  // w = {b[3i+2], b[3i+1], b[3i], b[3i-1]}; returns {sign, 4x, 3x, 2x, x}
  function automatic logic [4:0] booth_code(input logic [3:0] w);
    logic [4:0] c;
    case (w)
      4'b0001, 4'b0010: c = 5'b00001;
      4'b0011, 4'b0100: c = 5'b00010;
      4'b0101, 4'b0110: c = 5'b00100;
      4'b0111:          c = 5'b01000;
      4'b1000:          c = 5'b11000;
      4'b1001, 4'b1010: c = 5'b10100;
      4'b1011, 4'b1100: c = 5'b10010;
      4'b1101, 4'b1110: c = 5'b10001;
      default:          c = 5'b00000;
    endcase
    return c;
  endfunction

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !rst && (!s1_valid || s2_load);
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = s2_valid;

  always_comb begin
    b_ext  = {b, 1'b0};
    lo_sum = (LOW_W + 1)'(LOW_W'({2'b00, a})) + (LOW_W + 1)'(LOW_W'({1'b0, a, 1'b0}));
    for (int i = 0; i < 8; i++) begin
      code_nxt[i] = booth_code(b_ext[3*i +: 4]);
    end
  end

  // Upper half of 3a finishes in stage 2, using the carry out of the stage-1 low adder.
  assign hi_sum = HI_W'({2'b00, s1_a} >> LOW_W) + HI_W'({1'b0, s1_x2} >> LOW_W) + HI_W'(s1_cy);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_a     <= '0;
      s1_code  <= '0;
      s1_x2    <= '0;
      s1_x4    <= '0;
      s1_lo    <= '0;
      s1_cy    <= 1'b0;
      x        <= '0;
      x_2      <= '0;
      x_3      <= '0;
      x_4      <= '0;
      BEU_out  <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_xfer) begin
        s1_a    <= a;
        s1_code <= code_nxt;
        s1_x2   <= {a, 1'b0};
        s1_x4   <= {a, 2'b00};
        s1_lo   <= lo_sum[LOW_W-1:0];
        s1_cy   <= lo_sum[LOW_W];
      end
      if (s2_load) begin
        s2_valid <= 1'b1;
        x        <= s1_a;
        x_2      <= s1_x2;
        x_3      <= {hi_sum, s1_lo};
        x_4      <= s1_x4;
        BEU_out  <= s1_code;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule
